hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed-depth forwarding and exception-control pair in the pipelined miniRV core.
- Tracks in-flight register writers across STAGES post-decode stages in a shift-register scoreboard, selects per-operand forwarding data, and raises load-use stalls for a configurable load latency.
- Honours a memory-bus wait freeze and a branch flush from EX.
- Sits beside ID; its outputs drive the IF/ID hold, the ID/EX bubble and the EX operand muxes.

Parameters:
- XLEN, 32, data width of forwarded values.
- REG_AW, 5, register index width.
- NSRC, 2, number of source operands checked per decoded instruction.
- STAGES, 3, scoreboard depth; entry 1 = EX, entry STAGES = WB.
- LOAD_LAT, 2, first scoreboard entry index at which load data is valid in stage_data (2 = MEM output); legal range 1..STAGES.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  NSRC*REG_AW  source register indices; operand j at [j*REG_AW +: REG_AW].
- id_rs_used  in  NSRC  operand j is actually read.
- id_wr  in  REG_AW  destination register.
- id_we  in  1  instruction writes id_wr.
- id_is_load  in  1  instruction is a load.
- stage_data  in  STAGES*XLEN  value that will be written back, per scoreboard entry k (entry k at [(k-1)*XLEN +: XLEN]).
- mem_wait  in  1  memory bus not ready; whole pipeline frozen this cycle.
- flush  in  1  taken branch/jump resolved in EX; kills the ID instruction.
- stall_id  out  1  hold PC and IF/ID; insert a bubble into ID/EX.
- fwd_valid  out  NSRC  operand j takes forwarded data instead of the register-file value.
- fwd_data  out  NSRC*XLEN  forwarded value per operand.

Behaviour:
- Scoreboard entry k (1..STAGES) holds {v, wr, ld}. Reset clears all v to 0. With all entries invalid, stall_id = 0 and fwd_valid = 0; fwd_data = 0 when not forwarding.
- Update, only when mem_wait = 0:
  - Entry 1 is loaded with {1, id_wr, id_is_load} iff id_valid & id_we & (id_wr != 0) & !stall_id & !flush; otherwise entry 1 gets v = 0.
  - Entry k gets entry k-1 for k >= 2. Entry STAGES retires.
- When mem_wait = 1, all entries hold. Outputs remain combinationally valid against the held state.
- Match for operand j: id_rs_used[j], rs_j != 0, v_k = 1 and wr_k = rs_j. The youngest matching entry (smallest k) wins; older matches are ignored.
- Winning entry is ready iff !ld_k | (k >= LOAD_LAT).
  - Ready: fwd_valid[j] = 1, fwd_data[j] = stage_data[k].
  - Not ready: hazard_j = 1, fwd_valid[j] = 0.
- No match: fwd_valid[j] = 0 (register file supplies the value; the register file is write-first, so retirement and read in the same cycle are safe).
- stall_id = id_valid & !flush & OR(hazard_j). It is purely combinational, with zero-cycle latency from scoreboard state.
- A load followed immediately by a dependent instruction stalls LOAD_LAT-1 cycles, then forwards from entry LOAD_LAT.
- flush and hazard in the same cycle: flush wins; stall_id = 0; entry 1 gets a bubble.
- flush is only acted on when mem_wait = 0. EX holds the branch, so flush persists through a freeze.
- Reset asserted mid-operation clears all entries immediately (asynchronous); the first post-reset cycle sees an empty scoreboard.
- x0 is never tracked and never matched.

Optional Feature:
- Macro HAZARD_STATS_EN.
- When defined, adds three 32-bit outputs: stat_stall, stat_fwd, stat_flush. They are reset to 0 and count, respectively:
  - cycles with stall_id = 1 and mem_wait = 0;
  - cycles with any fwd_valid = 1, id_valid = 1, mem_wait = 0 and stall_id = 0;
  - cycles with flush = 1 and mem_wait = 0.
- Counters saturate at 0xFFFFFFFF.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- ALU chain (defaults): cycle 0 ID add x5 (we), cycle 1 ID add x6,x5,x5 with stage_data[entry1] = 0x1234 -> fwd_valid = 2'b11, fwd_data both 0x1234, stall_id = 0.
- Load-use: lw x7 then sw reading x7 on operand 1 -> stall_id = 1 for exactly 1 cycle. Next cycle fwd_valid[1] = 1 from entry 2 with stage_data = 0xDEADBEEF. With LOAD_LAT = 3 the stall lasts 2 cycles.
- Priority: writers of x3 in entries 1 and 3 (entry 1 data 0xA, entry 3 data 0xB), ID reads x3 -> fwd_data = 0xA.
- Freeze: load in entry 1, mem_wait = 1 for 4 cycles -> scoreboard unchanged and stall_id stays 1 throughout. After release, the dependent instruction forwards one cycle later.
- Flush: flush = 1 while ID has a hazard on x4 -> stall_id = 0; entry 1 gets v = 0 next cycle; x0 destination/source never tracked or forwarded.
- Reset: assert rst_n = 0 mid-load-stall -> stall_id and fwd_valid drop to 0 immediately; all entries invalid on release. With HAZARD_STATS_EN, all stat counters read 0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks in-flight register writers over STAGES
// post-decode stages, selects per-operand forwarding data and raises
// load-use stalls for a configurable load latency.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   id_valid       ID holds a real instruction
//   id_rs          NSRC source indices, operand j at [j*REG_AW +: REG_AW]
//   id_rs_used     operand j is actually read
//   id_wr, id_we   destination register and its write enable
//   id_is_load     ID instruction is a load
//   stage_data     write-back value per entry k at [(k-1)*XLEN +: XLEN]
//   mem_wait       whole pipeline frozen this cycle
//   flush          taken branch/jump in EX kills the ID instruction
//   stall_id       hold PC and IF/ID, bubble into ID/EX
//   fwd_valid      operand j takes forwarded data
//   fwd_data       forwarded value per operand (0 when not forwarding)
//
// Optional: define HAZARD_STATS_EN to add saturating 32-bit counters
// stat_stall, stat_fwd and stat_flush.

module hazard_scoreboard #(
    parameter int XLEN     = 32,
    parameter int REG_AW   = 5,
    parameter int NSRC     = 2,
    parameter int STAGES   = 3,
    parameter int LOAD_LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic [NSRC*REG_AW-1:0] id_rs,
    input  logic [NSRC-1:0]        id_rs_used,
    input  logic [REG_AW-1:0]      id_wr,
    input  logic                   id_we,
    input  logic                   id_is_load,
    input  logic [STAGES*XLEN-1:0] stage_data,
    input  logic                   mem_wait,
    input  logic                   flush,
    output logic                   stall_id,
    output logic [NSRC-1:0]        fwd_valid,
    output logic [NSRC*XLEN-1:0]   fwd_data
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]            stat_stall,
    output logic [31:0]            stat_fwd,
    output logic [31:0]            stat_flush
`endif
);

    // Scoreboard entries, index 1 = EX, index STAGES = WB.
    logic [STAGES:1]   sb_v;
    logic [STAGES:1]   sb_ld;
    logic [REG_AW-1:0] sb_wr [1:STAGES];

    logic [NSRC-1:0]   hazard;
    logic              issue;

    // -----------------------------------------------------------------
    // Per-operand match and forwarding select
    // -----------------------------------------------------------------
    for (genvar j = 0; j < NSRC; j++) begin : g_op
        logic [REG_AW-1:0] rs;
        logic              op_hit;
        logic              op_ready;
        logic [XLEN-1:0]   op_data;

        assign rs = id_rs[j*REG_AW +: REG_AW];

        // Walk oldest to youngest so the youngest match overrides.
        always_comb begin
            op_hit   = 1'b0;
            op_ready = 1'b0;
            op_data  = '0;
            for (int k = STAGES; k >= 1; k--) begin
                if (id_rs_used[j] && (rs != '0) &&
                    sb_v[k] && (sb_wr[k] == rs)) begin
                    op_hit   = 1'b1;
                    op_ready = !sb_ld[k] || (k >= LOAD_LAT);
                    op_data  = stage_data[(k-1)*XLEN +: XLEN];
                end
            end
        end

        assign fwd_valid[j] = op_hit & op_ready;
        assign hazard[j]    = op_hit & ~op_ready;
        assign fwd_data[j*XLEN +: XLEN] =
            (op_hit & op_ready) ? op_data : '0;
    end

    // Flush wins over any hazard: the ID instruction is dead anyway.
    assign stall_id = id_valid & ~flush & (|hazard);

    // x0 writers are never entered, so they can never be matched.
    assign issue = id_valid & id_we & (id_wr != '0) &
                   ~stall_id & ~flush;

    // -----------------------------------------------------------------
    // Shift-register scoreboard, frozen while mem_wait is high
    // -----------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_v  <= '0;
            sb_ld <= '0;
            for (int k = 1; k <= STAGES; k++) begin
                sb_wr[k] <= '0;
            end
        end else if (!mem_wait) begin
            sb_v[1]  <= issue;
            sb_ld[1] <= issue & id_is_load;
            sb_wr[1] <= id_wr;
            for (int k = 2; k <= STAGES; k++) begin
                sb_v[k]  <= sb_v[k-1];
                sb_ld[k] <= sb_ld[k-1];
                sb_wr[k] <= sb_wr[k-1];
            end
        end
    end

`ifdef HAZARD_STATS_EN
    // -----------------------------------------------------------------
    // Saturating event counters
    // -----------------------------------------------------------------
    logic ev_stall;
    logic ev_fwd;
    logic ev_flush;

    assign ev_stall = stall_id & ~mem_wait;
    assign ev_fwd   = (|fwd_valid) & id_valid & ~mem_wait & ~stall_id;
    assign ev_flush = flush & ~mem_wait;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_stall <= '0;
            stat_fwd   <= '0;
            stat_flush <= '0;
        end else begin
            if (ev_stall && (stat_stall != '1)) begin
                stat_stall <= stat_stall + 32'd1;
            end
            if (ev_fwd && (stat_fwd != '1)) begin
                stat_fwd <= stat_fwd + 32'd1;
            end
            if (ev_flush && (stat_flush != '1)) begin
                stat_flush <= stat_flush + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed testbench for hazard_scoreboard: two instances with
// LOAD_LAT = 2 and LOAD_LAT = 3 driven by the same stimulus.

module tb_hazard_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [9:0]  id_rs;
    logic [1:0]  id_rs_used;
    logic [4:0]  id_wr;
    logic        id_we;
    logic        id_is_load;
    logic [95:0] stage_data;
    logic        mem_wait;
    logic        flush;

    logic        stall2;
    logic [1:0]  fv2;
    logic [63:0] fd2;
    logic        stall3;
    logic [1:0]  fv3;
    logic [63:0] fd3;

`ifdef HAZARD_STATS_EN
    logic [31:0] st_stall2, st_fwd2, st_flush2;
    logic [31:0] st_stall3, st_fwd3, st_flush3;
`endif

    logic [31:0] sd [1:3];
    assign stage_data = {sd[3], sd[2], sd[1]};

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    hazard_scoreboard u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rs_used (id_rs_used),
        .id_wr      (id_wr),
        .id_we      (id_we),
        .id_is_load (id_is_load),
        .stage_data (stage_data),
        .mem_wait   (mem_wait),
        .flush      (flush),
        .stall_id   (stall2),
        .fwd_valid  (fv2),
        .fwd_data   (fd2)
`ifdef HAZARD_STATS_EN
        ,
        .stat_stall (st_stall2),
        .stat_fwd   (st_fwd2),
        .stat_flush (st_flush2)
`endif
    );

    hazard_scoreboard #(.LOAD_LAT(3)) u_dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rs_used (id_rs_used),
        .id_wr      (id_wr),
        .id_we      (id_we),
        .id_is_load (id_is_load),
        .stage_data (stage_data),
        .mem_wait   (mem_wait),
        .flush      (flush),
        .stall_id   (stall3),
        .fwd_valid  (fv3),
        .fwd_data   (fd3)
`ifdef HAZARD_STATS_EN
        ,
        .stat_stall (st_stall3),
        .stat_fwd   (st_fwd3),
        .stat_flush (st_flush3)
`endif
    );

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_id(input logic       v,
                            input logic [4:0] r0,
                            input logic [4:0] r1,
                            input logic [1:0] used,
                            input logic [4:0] wr,
                            input logic       we,
                            input logic       ld);
        id_valid   = v;
        id_rs      = {r1, r0};
        id_rs_used = used;
        id_wr      = wr;
        id_we      = we;
        id_is_load = ld;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic drain;
        drive_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
        repeat (3) tick();
    endtask

    initial begin
        rst_n    = 1'b0;
        mem_wait = 1'b0;
        flush    = 1'b0;
        sd[1]    = 32'h0;
        sd[2]    = 32'h0;
        sd[3]    = 32'h0;
        drive_id(1'b1, 5'd7, 5'd7, 2'b11, 5'd0, 1'b0, 1'b0);
        #3;
        check("rst_stall", {63'd0, stall2}, 64'd0);
        check("rst_fwdv", {62'd0, fv2}, 64'd0);
        check("rst_fwdd", fd2, 64'd0);
        check("rst_stall3", {63'd0, stall3}, 64'd0);
`ifdef HAZARD_STATS_EN
        check("rst_stats", {32'd0, st_stall2 | st_fwd2 | st_flush2},
              64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ALU chain: add x5, then add x6,x5,x5
        drive_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0);
        settle();
        check("alu_nostall", {63'd0, stall2}, 64'd0);
        tick();
        drive_id(1'b1, 5'd5, 5'd5, 2'b11, 5'd6, 1'b1, 1'b0);
        sd[1] = 32'h1234;
        settle();
        check("alu_fwdv", {62'd0, fv2}, 64'd3);
        check("alu_fwdd", fd2, 64'h0000_1234_0000_1234);
        check("alu_stall", {63'd0, stall2}, 64'd0);
        check("alu_fwdv3", {62'd0, fv3}, 64'd3);
        drain();

        // Load-use: lw x7, then sw reading x7 on operand 1
        drive_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1);
        tick();
        drive_id(1'b1, 5'd0, 5'd7, 2'b10, 5'd0, 1'b0, 1'b0);
        sd[1] = 32'h1111;
        sd[2] = 32'hDEAD_BEEF;
        sd[3] = 32'h3333;
        settle();
        check("lu_stall_c1", {63'd0, stall2}, 64'd1);
        check("lu_stall3_c1", {63'd0, stall3}, 64'd1);
        check("lu_fwdv_c1", {62'd0, fv2}, 64'd0);
        check("lu_fwdd_c1", fd2, 64'd0);
        tick();
        check("lu_stall_c2", {63'd0, stall2}, 64'd0);
        check("lu_fwdv_c2", {62'd0, fv2}, 64'd2);
        check("lu_fwdd_c2", fd2, 64'hDEAD_BEEF_0000_0000);
        check("lu_stall3_c2", {63'd0, stall3}, 64'd1);
        tick();
        check("lu_stall3_c3", {63'd0, stall3}, 64'd0);
        check("lu_fwdv3_c3", {62'd0, fv3}, 64'd2);
        check("lu_fwdd3_c3", fd3, 64'h0000_3333_0000_0000);
        drain();

        // Priority: x3 in entries 1 and 3, x9 in entry 2
        drive_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b0);
        tick();
        drive_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 1'b0);
        tick();
        drive_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b0);
        tick();
        sd[1] = 32'hA;
        sd[2] = 32'hC;
        sd[3] = 32'hB;
        drive_id(1'b1, 5'd3, 5'd8, 2'b11, 5'd0, 1'b0, 1'b0);
        settle();
        check("pri_fwdv", {62'd0, fv2}, 64'd1);
        check("pri_fwdd", fd2, 64'h0000_0000_0000_000A);
        check("pri_fwdv3", {62'd0, fv3}, 64'd1);
        drive_id(1'b1, 5'd3, 5'd3, 2'b00, 5'd0, 1'b0, 1'b0);
        settle();
        check("unused_fwdv", {62'd0, fv2}, 64'd0);
        check("unused_fwdd", fd2, 64'd0);
        drive_id(1'b1, 5'd0, 5'd9, 2'b10, 5'd0, 1'b0, 1'b0);
        settle();
        check("mid_fwdv", {62'd0, fv2}, 64'd2);
        check("mid_fwdd", fd2, 64'h0000_000C_0000_0000);
        drain();

        // Freeze: load x10 in entry 1, dependent waits under mem_wait
        drive_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd10, 1'b1, 1'b1);
        tick();
        drive_id(1'b1, 5'd10, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);
        sd[1] = 32'h1;
        sd[2] = 32'h55;
        sd[3] = 32'h66;
        mem_wait = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("frz_stall", {63'd0, stall2}, 64'd1);
            check("frz_fwdv", {62'd0, fv2}, 64'd0);
            tick();
        end
        mem_wait = 1'b0;
        settle();
        check("frz_rel_stall", {63'd0, stall2}, 64'd1);
        tick();
        check("frz_fwdv", {62'd0, fv2}, 64'd1);
        check("frz_fwdd", fd2, 64'h0000_0000_0000_0055);
        check("frz_stall_end", {63'd0, stall2}, 64'd0);
        check("frz_stall3", {63'd0, stall3}, 64'd1);
        tick();
        check("frz_fwdv3", {62'd0, fv3}, 64'd1);
        check("frz_fwdd3", fd3, 64'h0000_0000_0000_0066);
        drain();

        // Flush over a hazard on x4; flushed writer x12 not entered
        drive_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b1);
        tick();
        drive_id(1'b1, 5'd4, 5'd0, 2'b01, 5'd12, 1'b1, 1'b0);
        flush = 1'b1;
        sd[2] = 32'h44;
        settle();
        check("fl_stall", {63'd0, stall2}, 64'd0);
        check("fl_stall3", {63'd0, stall3}, 64'd0);
        check("fl_fwdv", {62'd0, fv2}, 64'd0);
        tick();
        flush = 1'b0;
        drive_id(1'b1, 5'd12, 5'd4, 2'b11, 5'd0, 1'b0, 1'b0);
        settle();
        check("fl_bubble_fwdv", {62'd0, fv2}, 64'd2);
        check("fl_bubble_fwdd", fd2, 64'h0000_0044_0000_0000);
        check("fl_bubble_stall", {63'd0, stall2}, 64'd0);
        check("fl_bubble_stall3", {63'd0, stall3}, 64'd1);
        check("fl_bubble_fwdv3", {62'd0, fv3}, 64'd0);
        drain();

        // x0 destination (load) and x0 sources
        drive_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b1);
        tick();
        drive_id(1'b1, 5'd0, 5'd0, 2'b11, 5'd0, 1'b0, 1'b0);
        settle();
        check("x0_fwdv", {62'd0, fv2}, 64'd0);
        check("x0_stall", {63'd0, stall2}, 64'd0);
        drain();

        // Reset in the middle of a load-use stall
        drive_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1);
        tick();
        drive_id(1'b1, 5'd7, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);
        settle();
        check("mr_pre_stall", {63'd0, stall2}, 64'd1);
        settle();
        rst_n = 1'b0;
        settle();
        check("mr_stall", {63'd0, stall2}, 64'd0);
        check("mr_stall3", {63'd0, stall3}, 64'd0);
        check("mr_fwdv", {62'd0, fv2}, 64'd0);
`ifdef HAZARD_STATS_EN
        check("mr_stats", {32'd0, st_stall2 | st_fwd2 | st_flush2},
              64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_stall", {63'd0, stall2}, 64'd0);
        check("post_rst_stall3", {63'd0, stall3}, 64'd0);
        check("post_rst_fwdv", {62'd0, fv2}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
